// File: rtl/mips_core_pkg.sv
// Shared types and sizing for the load value speculator and its snapshot bank.
package mips_core_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned REGFILE_BITS = NUM_REGS * DATA_WIDTH;
  localparam int unsigned INDEX_BITS   = 6;
  localparam int unsigned CONF_BITS    = 2;
  localparam int unsigned CONF_THRESH  = 2;
  localparam int unsigned TABLE_DEPTH  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS     = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_action_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SPEC,
    TRAIN,
    RECOVER
  } vp_state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS-1:0]   tag;
    logic [DATA_WIDTH-1:0] value;
    logic [CONF_BITS-1:0]  conf;
  } vp_entry_t;

  // Saturating confidence increment; never wraps back to zero.
  function automatic logic [CONF_BITS-1:0] conf_inc(input logic [CONF_BITS-1:0] c);
    return (c == {CONF_BITS{1'b1}}) ? c : c + CONF_BITS'(1);
  endfunction

endpackage

// File: rtl/reg_snapshot_bank.sv
// Architectural register file copy taken when a speculation episode starts.
module reg_snapshot_bank
  import mips_core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    capture,
  input  logic [REGFILE_BITS-1:0] regs_in,
  output logic [REGFILE_BITS-1:0] regs_out,
  output logic                    captured
);

  logic [REGFILE_BITS-1:0] regs_q;
  logic                    captured_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      captured_q <= 1'b0;
    end else begin
      captured_q <= capture;
      if (capture) begin
        regs_q <= regs_in;
      end
    end
  end

  assign regs_out = regs_q;
  assign captured = captured_q;

endmodule

// File: rtl/load_value_speculator.sv
// Last-value load predictor: PC-indexed table, speculative issue, verify and recover.
module load_value_speculator
  import mips_core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vp_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    d_cache_req_valid,
  input  logic                    d_cache_req_mem_action,
  input  logic [ADDR_WIDTH-1:0]   d_cache_req_addr,
  input  logic                    d_cache_data_valid,
  input  logic [DATA_WIDTH-1:0]   d_cache_data_data,
  input  logic [REGFILE_BITS-1:0] regs_in,
  output logic [REGFILE_BITS-1:0] regs_snapshot,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    out_valid,
  output logic                    vp_lock_out,
  output logic                    en_recover,
  input  logic                    recovery_done,
  output logic                    recovery_done_ack,
  output logic                    done
);

  vp_entry_t             table_q [TABLE_DEPTH];
  vp_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  lock_q, lock_d;
  logic                  recover_q, recover_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  out_valid_prev_q;

  logic                  tbl_we;
  vp_entry_t             tbl_wdata;
  logic                  snap_capture;
  logic                  snap_captured;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  vp_entry_t             cur;
  logic                  tag_match;
  logic                  hit;
  logic                  write_req;
  logic                  unused_bits;

  assign idx         = addr_q[INDEX_BITS+1:2];
  assign tag         = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign cur         = table_q[idx];
  assign tag_match   = cur.valid && (cur.tag == tag);
  assign hit         = tag_match && (cur.conf >= CONF_BITS'(CONF_THRESH));
  assign write_req   = d_cache_req_valid && (mem_action_t'(d_cache_req_mem_action) == WRITE);
  assign unused_bits = ^{addr_q[1:0], d_cache_req_addr};

  reg_snapshot_bank u_snapshot (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (snap_capture),
    .regs_in  (regs_in),
    .regs_out (regs_snapshot),
    .captured (snap_captured)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      out_q            <= '0;
      out_valid_q      <= 1'b0;
      lock_q           <= 1'b0;
      recover_q        <= 1'b0;
      ack_q            <= 1'b0;
      done_q           <= 1'b0;
      out_valid_prev_q <= 1'b0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      out_q            <= out_d;
      out_valid_q      <= out_valid_d;
      lock_q           <= lock_d;
      recover_q        <= recover_d;
      ack_q            <= ack_d;
      done_q           <= done_d;
      out_valid_prev_q <= out_valid_q;
      if (tbl_we) begin
        table_q[idx] <= tbl_wdata;
      end
      // A prediction must never become visible before its snapshot is in place.
      if (out_valid_q && !out_valid_prev_q) begin
        assert (snap_captured);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    lock_d       = lock_q;
    recover_d    = recover_q;
    ack_d        = 1'b0;
    done_d       = 1'b0;
    tbl_we       = 1'b0;
    tbl_wdata    = cur;
    snap_capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (vp_en && !write_req) begin
          addr_d  = addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          out_d        = cur.value;
          out_valid_d  = 1'b1;
          lock_d       = 1'b1;
          snap_capture = 1'b1;
          state_d      = SPEC;
        end else begin
          out_valid_d = 1'b0;
          state_d     = TRAIN;
        end
      end
      SPEC: begin
        if (d_cache_data_valid) begin
          tbl_we      = 1'b1;
          out_valid_d = 1'b0;
          if (d_cache_data_data == out_q) begin
            tbl_wdata.conf = conf_inc(cur.conf);
            done_d         = 1'b1;
            lock_d         = 1'b0;
            state_d        = IDLE;
          end else begin
            tbl_wdata.value = d_cache_data_data;
            tbl_wdata.conf  = '0;
            recover_d       = 1'b1;
            state_d         = RECOVER;
          end
        end
      end
      TRAIN: begin
        if (d_cache_data_valid) begin
          tbl_we  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
          if (tag_match) begin
            if (d_cache_data_data == cur.value) begin
              tbl_wdata.conf = conf_inc(cur.conf);
            end else begin
              tbl_wdata.value = d_cache_data_data;
              tbl_wdata.conf  = '0;
            end
          end else begin
            tbl_wdata.valid = 1'b1;
            tbl_wdata.tag   = tag;
            tbl_wdata.value = d_cache_data_data;
            tbl_wdata.conf  = '0;
          end
        end
      end
      RECOVER: begin
        if (recovery_done) begin
          ack_d     = 1'b1;
          done_d    = 1'b1;
          recover_d = 1'b0;
          lock_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out               = out_q;
  assign out_valid         = out_valid_q;
  assign vp_lock_out       = lock_q;
  assign en_recover        = recover_q;
  assign recovery_done_ack = ack_q;
  assign done              = done_q;

endmodule

// File: tb/tb_load_value_speculator.sv
// Directed plus randomized episodes against a table-level model of the predictor.
module tb_load_value_speculator;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vp_en;
  logic [31:0]   addr;
  logic          d_cache_req_valid;
  logic          d_cache_req_mem_action;
  logic [31:0]   d_cache_req_addr;
  logic          d_cache_data_valid;
  logic [31:0]   d_cache_data_data;
  logic [1023:0] regs_in;
  logic [1023:0] regs_snapshot;
  logic [31:0]   out_w;
  logic          out_valid;
  logic          vp_lock_out;
  logic          en_recover;
  logic          recovery_done;
  logic          recovery_done_ack;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic          m_valid [64];
  logic [23:0]   m_tag   [64];
  logic [31:0]   m_value [64];
  int            m_conf  [64];
  logic [1023:0] m_snap;

  always #5 clk = ~clk;

  load_value_speculator dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .vp_en                  (vp_en),
    .addr                   (addr),
    .d_cache_req_valid      (d_cache_req_valid),
    .d_cache_req_mem_action (d_cache_req_mem_action),
    .d_cache_req_addr       (d_cache_req_addr),
    .d_cache_data_valid     (d_cache_data_valid),
    .d_cache_data_data      (d_cache_data_data),
    .regs_in                (regs_in),
    .regs_snapshot          (regs_snapshot),
    .out                    (out_w),
    .out_valid              (out_valid),
    .vp_lock_out            (vp_lock_out),
    .en_recover             (en_recover),
    .recovery_done          (recovery_done),
    .recovery_done_ack      (recovery_done_ack),
    .done                   (done)
  );

  function automatic logic [1023:0] rand_regs();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_value[i] = '0;
      m_conf[i]  = 0;
    end
    m_snap = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, out_w, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_lock"}, vp_lock_out, 0);
    chk({tag, "_recover"}, en_recover, 0);
    chk({tag, "_ack"}, recovery_done_ack, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_snapshot"}, regs_snapshot, 0);
  endtask

  // One full load episode, starting and ending at a negedge with the DUT idle.
  task automatic episode(input logic [31:0] pc, input logic [31:0] data, input int dly, input int rdly);
    int            idx;
    logic [23:0]   tg;
    logic          hit;
    logic [1023:0] regs_v;
    idx    = int'(pc[7:2]);
    tg     = pc[31:8];
    hit    = m_valid[idx] && (m_tag[idx] == tg) && (m_conf[idx] >= 2);
    regs_v = rand_regs();
    regs_in = regs_v;
    addr = pc;
    d_cache_req_valid = 1'b1;
    d_cache_req_mem_action = 1'b0;
    d_cache_req_addr = pc;
    vp_en = 1'b1;
    @(negedge clk);
    vp_en = 1'b0;
    chk("lookup_out_valid", out_valid, 0);
    chk("lookup_lock", vp_lock_out, 0);
    @(negedge clk);
    chk("issue_out_valid", out_valid, hit);
    chk("issue_lock", vp_lock_out, hit);
    if (hit) begin
      chk("issue_out", out_w, m_value[idx]);
      m_snap = regs_v;
    end
    chk("issue_snapshot", regs_snapshot, m_snap);
    regs_in = rand_regs();
    for (int w = 0; w < dly; w++) begin
      vp_en = 1'($urandom_range(0, 1));
      addr = $urandom;
      @(negedge clk);
      chk("wait_out_valid", out_valid, hit);
      chk("wait_lock", vp_lock_out, hit);
      chk("wait_done", done, 0);
      chk("wait_snapshot", regs_snapshot, m_snap);
    end
    vp_en = 1'($urandom_range(0, 1));
    addr = $urandom;
    d_cache_data_valid = 1'b1;
    d_cache_data_data = data;
    @(negedge clk);
    d_cache_data_valid = 1'b0;
    vp_en = 1'b0;
    chk("resolve_out_valid", out_valid, 0);
    if (hit && data != m_value[idx]) begin
      m_value[idx] = data;
      m_conf[idx]  = 0;
      chk("mispredict_recover", en_recover, 1);
      chk("mispredict_lock", vp_lock_out, 1);
      chk("mispredict_done", done, 0);
      for (int r = 0; r < rdly; r++) begin
        vp_en = 1'($urandom_range(0, 1));
        addr = $urandom;
        @(negedge clk);
        vp_en = 1'b0;
        chk("recover_held", en_recover, 1);
        chk("recover_lock", vp_lock_out, 1);
        chk("recover_ack_early", recovery_done_ack, 0);
        chk("recover_snapshot", regs_snapshot, m_snap);
      end
      recovery_done = 1'b1;
      @(negedge clk);
      recovery_done = 1'b0;
      chk("ack_pulse", recovery_done_ack, 1);
      chk("ack_done", done, 1);
      chk("ack_recover_low", en_recover, 0);
      chk("ack_lock_low", vp_lock_out, 0);
    end else begin
      chk("resolve_done", done, 1);
      chk("resolve_lock", vp_lock_out, 0);
      chk("resolve_recover", en_recover, 0);
      if (m_valid[idx] && m_tag[idx] == tg) begin
        if (data == m_value[idx]) begin
          m_conf[idx] = (m_conf[idx] < 3) ? m_conf[idx] + 1 : 3;
        end else begin
          m_value[idx] = data;
          m_conf[idx]  = 0;
        end
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_value[idx] = data;
        m_conf[idx]  = 0;
      end
    end
    @(negedge clk);
    chk("end_done_low", done, 0);
    chk("end_ack_low", recovery_done_ack, 0);
    chk("end_snapshot", regs_snapshot, m_snap);
  endtask

  initial begin
    logic [31:0] pcs [6];
    logic [31:0] pc_a, pc_b, pc_r;
    pcs[0] = 32'h0040_0010; pcs[1] = 32'h0040_0110; pcs[2] = 32'h0040_0020;
    pcs[3] = 32'h0040_0024; pcs[4] = 32'h1000_0010; pcs[5] = 32'h0040_0210;
    pc_a = 32'h0040_0010;
    pc_b = 32'h0040_0110;
    pc_r = 32'h0040_0024;

    rst_n = 1'b0;
    vp_en = 1'b0;
    addr = '0;
    d_cache_req_valid = 1'b0;
    d_cache_req_mem_action = 1'b0;
    d_cache_req_addr = '0;
    d_cache_data_valid = 1'b0;
    d_cache_data_data = '0;
    regs_in = '0;
    recovery_done = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Cold load, two trainings, then a confident matching prediction.
    episode(pc_a, 32'h1234, 0, 0);
    episode(pc_a, 32'h1234, 1, 0);
    episode(pc_a, 32'h1234, 2, 0);
    episode(pc_a, 32'h1234, 2, 0);
    // Confident entry, wrong data: recovery held 5 cycles.
    episode(pc_a, 32'hBEEF, 1, 5);
    episode(pc_a, 32'hBEEF, 0, 0);
    episode(pc_a, 32'hBEEF, 0, 0);
    // Aliasing PC steals the entry; the original then misses.
    episode(pc_b, 32'h5555, 0, 0);
    episode(pc_a, 32'hBEEF, 0, 0);

    // A WRITE request with vp_en must not start an episode.
    vp_en = 1'b1;
    addr = pc_a;
    d_cache_req_valid = 1'b1;
    d_cache_req_mem_action = 1'b1;
    @(negedge clk);
    vp_en = 1'b0;
    d_cache_req_valid = 1'b0;
    d_cache_req_mem_action = 1'b0;
    d_cache_data_valid = 1'b1;
    d_cache_data_data = $urandom;
    chk("write_no_lock", vp_lock_out, 0);
    @(negedge clk);
    chk("write_no_done1", done, 0);
    @(negedge clk);
    d_cache_data_valid = 1'b0;
    chk("write_no_done2", done, 0);
    @(negedge clk);
    chk("write_no_done3", done, 0);

    // Randomized episodes over a small PC set with mostly repeating data.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] pc, dt;
      pc = pcs[$urandom_range(0, 5)];
      dt = ($urandom_range(0, 3) != 0) ? {pc[15:0], 16'h00AA} : $urandom;
      episode(pc, dt, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Reset in the middle of a speculation episode.
    episode(pc_r, 32'hCAFE_0001, 0, 0);
    episode(pc_r, 32'hCAFE_0001, 0, 0);
    episode(pc_r, 32'hCAFE_0001, 0, 0);
    regs_in = rand_regs();
    addr = pc_r;
    d_cache_req_valid = 1'b1;
    vp_en = 1'b1;
    @(negedge clk);
    vp_en = 1'b0;
    @(negedge clk);
    chk("prereset_out_valid", out_valid, 1);
    chk("prereset_lock", vp_lock_out, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    episode(pc_r, 32'hCAFE_0001, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
